// File: rtl/fetch_queue.sv
// fetch_queue: instruction/PC buffer between fetch and decode.
// A DEPTH-entry circular buffer with registered write pointer, read pointer
// and occupancy counter. Entries pushed on one edge become visible at the
// head on the following cycle; there is no same-cycle bypass.
//
// Ports:
//   clk        - single clock
//   reset      - asynchronous active-low reset
//   in_valid   - fetch presents in_inst/in_pc this cycle
//   in_inst    - instruction word
//   in_pc      - PC of in_inst
//   in_ready   - queue can take a push (count < DEPTH)
//   stall      - ~in_ready, holds the fetch PC
//   flush      - discard all queued entries on this edge
//   out_valid  - head entry valid (count != 0)
//   out_inst   - head instruction, NOP when empty
//   out_pc     - head PC, 0 when empty
//   out_ready  - decode consumes the head this cycle
//   count      - number of valid entries
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    output logic                     in_ready,
    output logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic push;
    logic pop;

    // Ready/valid depend on registered occupancy only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q < FULL);
    assign stall     = ~in_ready;
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign out_inst = out_valid ? inst_q[rd_ptr_q] : NOP;
    assign out_pc   = out_valid ? pc_q[rd_ptr_q]   : '0;

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flush leaves stale contents in place; the empty-output muxing hides them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_q[i] <= NOP;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            inst_q[wr_ptr_q] <= in_inst;
            pc_q[wr_ptr_q]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus for fetch_queue with a
// queue-based reference model; a monitor on the falling edge compares the
// DUT's observable state and every consumed head entry against a scoreboard.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents of the queue, oldest first, as {inst, pc}.
    logic [63:0] model [$];
    // Scoreboard of entries expected to be consumed, in order.
    logic [63:0] exp_q [$];
    int          exp_count = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for the coming edge and advance the model accordingly.
    task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl, output bit accepted);
        bit push_ok;
        bit pop_ok;
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        exp_count = model.size();
        push_ok   = iv && !fl && (model.size() < DEPTH);
        pop_ok    = rdy && !fl && (model.size() > 0);
        if (fl) begin
            model.delete();
        end else begin
            if (pop_ok)  exp_q.push_back(model.pop_front());
            if (push_ok) model.push_back({inst, pc});
        end
        accepted = push_ok;
    endtask

    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rdy, input logic fl, output bit accepted);
        @(posedge clk);
        #1;
        drive(iv, inst, pc, rdy, fl, accepted);
    endtask

    // Monitor: runs mid-cycle, while inputs for the next edge are stable.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mon_en) begin
            chk("count",     32'(count),     32'(exp_count));
            chk("in_ready",  32'(in_ready),  32'(exp_count < DEPTH));
            chk("stall",     32'(stall),     32'(exp_count >= DEPTH));
            chk("out_valid", 32'(out_valid), 32'(exp_count != 0));
            if (!out_valid) begin
                chk("empty_inst", out_inst, NOP);
                chk("empty_pc",   out_pc,   32'h0);
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("pop_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_inst", out_inst, e[63:32]);
                    chk("head_pc",   out_pc,   e[31:0]);
                end
            end
        end
    end

    initial begin
        bit          acc;
        int          idx;
        int          guard;
        logic [31:0] pc;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst",  out_inst,       NOP);
        chk("rst_out_pc",    out_pc,         32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_stall",     32'(stall),     32'd0);

        @(negedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
        mon_en = 1;

        // Basic order: three pushes held, then drained.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Fill: five pushes with no pops; the fifth waits for space.
        idx = 0;
        guard = 0;
        while (idx < 5 && guard < 20) begin
            step(1'b1, 32'h2000 + 32'(idx), 32'h200 + 32'(idx * 4), guard >= 7, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        chk("fill_done", 32'(idx), 32'd5);

        // Flush with concurrent push and pop; the push must never appear.
        step(1'b1, 32'hDEAD_BEEF, 32'hBAD0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Wrap: ten sequential PCs with out_ready toggling.
        idx = 0;
        guard = 0;
        while (idx < 10 && guard < 60) begin
            pc = 32'h100 + 32'(idx * 4);
            step(1'b1, 32'h3000 + 32'(idx), pc, guard[0], 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        chk("wrap_done", 32'(idx), 32'd10);
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Randomized traffic.
        pc = 32'h4000;
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom, pc, ($urandom % 2) != 0,
                 ($urandom % 16) == 0, acc);
            if (acc) pc = pc + 32'd4;
        end

        // Async reset with two entries queued.
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        step(1'b1, 32'h5000, 32'h500, 1'b0, 1'b0, acc);
        step(1'b1, 32'h5001, 32'h504, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #3;
        mon_en = 0;
        chk("pre_areset_count", 32'(count), 32'd2);
        reset = 1'b0;
        #1;
        chk("areset_count",     32'(count),     32'd0);
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_out_inst",  out_inst,       NOP);
        chk("areset_out_pc",    out_pc,         32'h0);
        chk("areset_stall",     32'(stall),     32'd0);
        chk("areset_sb_empty",  32'(exp_q.size()), 32'd0);
        model.delete();
        exp_q.delete();
        @(negedge clk);
        #1;
        reset = 1'b1;
        // First edge after release must take this push.
        drive(1'b1, 32'h6000, 32'h600, 1'b0, 1'b0, acc);
        mon_en = 1;
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        @(posedge clk);
        #1;
        mon_en = 0;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("final_count", 32'(count), 32'(model.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be a power of two, 2..16.
REQ-002 Parameter NOP, default 32'h00000013, instruction presented when the queue is empty or after reset.
REQ-003 clk  input  1  single clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  fetch presents a valid inst/pc pair this cycle.
REQ-006 in_inst  input  32  instruction word from instruction memory.
REQ-007 in_pc  input  32  PC of in_inst.
REQ-008 in_ready  output  1  queue accepts a push this cycle.
REQ-009 stall  output  1  equals ~in_ready; drives the fetch PC-hold input.
REQ-010 flush  input  1  discard all queued entries (taken branch, jal, jalr).
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_inst  output  32  head instruction.
REQ-013 out_pc  output  32  head PC.
REQ-014 out_ready  input  1  decode consumes the head this cycle.
REQ-015 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with write pointer, read pointer and occupancy counter, all registered.
REQ-017 Push SHALL occur on a rising clk edge when in_valid && in_ready && !flush; entry written at the write pointer, which then increments modulo DEPTH.
REQ-018 Pop SHALL occur on a rising clk edge when out_valid && out_ready && !flush; the read pointer increments modulo DEPTH.
REQ-019 in_ready SHALL be (count < DEPTH), a function of registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL be (count != 0); out_inst/out_pc SHALL be the entry at the read pointer when out_valid=1, else NOP and 32'h0.
REQ-021 Latency: a pushed entry SHALL become visible at the outputs the cycle after the push; no same-cycle bypass.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-023 Full (count == DEPTH): push blocked even if a pop occurs that cycle; pop proceeds; count becomes DEPTH-1.
REQ-024 Empty (count == 0): pop impossible; push proceeds; count becomes 1.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-026 flush=1 SHALL set count, write pointer and read pointer to 0 on that edge; any concurrent push and pop SHALL be ignored; out_valid SHALL be 0 the following cycle.
REQ-027 Entry contents need not be cleared by flush; outputs SHALL still show NOP/0 while empty.
REQ-028 count SHALL never exceed DEPTH or underflow below 0 for any input sequence.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for clk, force count=0, both pointers=0 and all entries to NOP / PC 0.
REQ-030 During and after reset: out_valid=0, out_inst=NOP, out_pc=0, in_ready=1, stall=0.
REQ-031 reset asserted mid-operation SHALL discard all entries; the first push after release is accepted on the first clk edge with reset=1.

Verification
REQ-032 Basic order: push pc 0x0,0x4,0x8 with out_ready=0, then out_ready=1 -> outputs 0x0,0x4,0x8 on consecutive cycles, then out_valid=0, out_inst=0x00000013.
REQ-033 Fill: DEPTH=4, push 5 entries with out_ready=0 -> count=4, in_ready=0, stall=1 after the 4th; the 5th is held and accepted only after a pop.
REQ-034 Full with simultaneous push/pop -> count 4 to 3, pushed data not taken that cycle; accepted next cycle with count back to 4.
REQ-035 Flush: 3 entries queued, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the flushed-cycle push is absent from all later output.
REQ-036 Wrap: stream 10 sequential PCs 0x100..0x124 with out_ready toggling 1/0 -> output order exact, count within 0..4 throughout.
REQ-037 Async reset: reset low between edges with count=2 -> count=0, out_valid=0 before the next clk edge.
